// File: rtl/pipe_field_renderer.sv
// Scrolling pipe obstacle field: pipe positions, gap randomisation, pass scoring and raster output.
// Optional macro PIPE_COLLISION_EN adds bird/pipe overlap detection and the HALT state.
module pipe_field_renderer #(
    parameter int NUM_PIPES     = 4,
    parameter int PIPE_WIDTH    = 40,
    parameter int PIPE_SPACING  = 220,
    parameter int SPEED_DIVIDER = 1_000_000,
    parameter int GAP_MIN_TOP   = 60,
    parameter int GAP_MAX_TOP   = 320,
    parameter int GAP_MIN_SIZE  = 110,
    parameter int GAP_MAX_SIZE  = 150,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               restart,
    input  logic [1:0]         speed_sel,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic [9:0]         bird_x,
    input  logic [9:0]         bird_y,
    input  logic [5:0]         bird_size,
    output logic               pipe_pixel,
    output logic               collision,
    output logic [SCORE_W-1:0] score,
    output logic               pass_pulse,
    output logic [1:0]         fsm_state
);

    localparam int RESPAWN_X  = 880;
    localparam int TOP_RANGE  = GAP_MAX_TOP - GAP_MIN_TOP + 1;
    localparam int SIZE_RANGE = GAP_MAX_SIZE - GAP_MIN_SIZE + 1;
    localparam int CNT_W      = (SPEED_DIVIDER > 1) ? $clog2(SPEED_DIVIDER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED_DIVIDER - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [10:0]      pipe_x   [NUM_PIPES];
    logic [9:0]       gap_top  [NUM_PIPES];
    logic [9:0]       gap_size [NUM_PIPES];
    logic [9:0]       lfsr;
    logic [CNT_W-1:0] step_cnt;

    logic [10:0] next_x   [NUM_PIPES];
    logic [9:0]  new_top  [NUM_PIPES];
    logic [9:0]  new_size [NUM_PIPES];
    logic        recycle  [NUM_PIPES];
    logic [10:0] speed_x;
    logic [10:0] others_max;
    logic [11:0] old_edge;
    logic [11:0] new_edge;
    logic [9:0]  lfsr_next;
    logic        taken;
    logic        any_pass;
    logic        hit;
    logic        step;

    function automatic logic [10:0] init_x(input int i);
        return 11'(RESPAWN_X + i * PIPE_SPACING);
    endfunction

    function automatic logic [9:0] init_top(input int i);
        return 10'(GAP_MIN_TOP + ((60 * i) % TOP_RANGE));
    endfunction

    assign fsm_state = state;
    assign collision = (state == ST_HALT);
    assign step      = (state == ST_SCROLL) && enable && !hit && (step_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:   if (enable) state_next = ST_SCROLL;
            ST_SCROLL: if (hit)    state_next = ST_HALT;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_WAIT;
        endcase
        if (restart) begin
            state_next = ST_WAIT;
        end
    end

    // Next positions are all derived from pre-step values; only the lowest
    // index among the exhausted pipes is respawned on a given step.
    always_comb begin
        speed_x    = 11'(speed_sel) + 11'd1;
        taken      = 1'b0;
        any_pass   = 1'b0;
        others_max = '0;
        old_edge   = '0;
        new_edge   = '0;
        lfsr_next  = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        for (int i = 0; i < NUM_PIPES; i++) begin
            others_max = 11'(RESPAWN_X - PIPE_SPACING);
            for (int j = 0; j < NUM_PIPES; j++) begin
                if (j != i && pipe_x[j] > others_max) begin
                    others_max = pipe_x[j];
                end
            end
            recycle[i] = 1'b0;
            if (pipe_x[i] > speed_x) begin
                next_x[i] = pipe_x[i] - speed_x;
            end else if (!taken) begin
                next_x[i]  = others_max + 11'(PIPE_SPACING);
                recycle[i] = 1'b1;
                taken      = 1'b1;
            end else begin
                next_x[i] = pipe_x[i];
            end
            new_top[i]  = 10'(GAP_MIN_TOP + int'(lfsr ^ 10'(i * 10'h0B5)) % TOP_RANGE);
            new_size[i] = 10'(GAP_MIN_SIZE + int'(lfsr[9:3] ^ 7'(i)) % SIZE_RANGE);
            old_edge = 12'(pipe_x[i]) + 12'(PIPE_WIDTH);
            new_edge = 12'(next_x[i]) + 12'(PIPE_WIDTH);
            if (old_edge >= 12'(bird_x) && new_edge < 12'(bird_x)) begin
                any_pass = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || restart || state == ST_WAIT) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x[i]   <= init_x(i);
                gap_top[i]  <= init_top(i);
                gap_size[i] <= 10'(GAP_MIN_SIZE);
            end
            lfsr       <= 10'h3FF;
            step_cnt   <= '0;
            score      <= '0;
            pass_pulse <= 1'b0;
        end else begin
            pass_pulse <= step && any_pass;
            if (state == ST_SCROLL && enable && !hit) begin
                step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + CNT_W'(1);
            end
            if (step) begin
                lfsr <= lfsr_next;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    pipe_x[i] <= next_x[i];
                    if (recycle[i]) begin
                        gap_top[i]  <= new_top[i];
                        gap_size[i] <= new_size[i];
                    end
                end
                if (any_pass && score != '1) begin
                    score <= score + SCORE_W'(1);
                end
            end
        end
    end

    logic [11:0] pix_edge;
    logic [10:0] pix_gap_end;

    always_comb begin
        pipe_pixel  = 1'b0;
        pix_edge    = '0;
        pix_gap_end = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pix_edge    = 12'(pipe_x[i]) + 12'(PIPE_WIDTH);
            pix_gap_end = 11'(gap_top[i]) + 11'(gap_size[i]);
            if (12'(hCount) >= 12'(pipe_x[i]) && 12'(hCount) < pix_edge &&
                (vCount < gap_top[i] || 11'(vCount) >= pix_gap_end)) begin
                pipe_pixel = 1'b1;
            end
        end
    end

`ifdef PIPE_COLLISION_EN
    logic [11:0] hit_edge;
    logic [11:0] hit_gap_end;

    // A zero-size bird is an empty box and never collides.
    always_comb begin
        hit         = 1'b0;
        hit_edge    = '0;
        hit_gap_end = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            hit_edge    = 12'(pipe_x[i]) + 12'(PIPE_WIDTH);
            hit_gap_end = 12'(gap_top[i]) + 12'(gap_size[i]);
            if (state == ST_SCROLL && bird_size != '0 &&
                12'(bird_x) < hit_edge &&
                12'(bird_x) + 12'(bird_size) > 12'(pipe_x[i]) &&
                (12'(bird_y) < 12'(gap_top[i]) ||
                 12'(bird_y) + 12'(bird_size) > hit_gap_end)) begin
                hit = 1'b1;
            end
        end
    end
`else
    logic unused_bird;
    assign unused_bird = ^{bird_y, bird_size};
    assign hit         = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_field_renderer.sv
// Self-checking bench for pipe_field_renderer: pixel table, scroll timing,
// recycle, pass scoring, hold/restart/reset, collision and score saturation.
module tb_pipe_field_renderer;

    logic       clk = 1'b0;
    logic       reset_n, enable, restart;
    logic [1:0] speed_sel;
    logic [9:0] hcount, vcount, bird_x, bird_y;
    logic [5:0] bird_size;
    logic       pipe_pixel, collision, pass_pulse;
    logic [7:0] score;
    logic [1:0] fsm_state;

    logic       sat_reset_n, sat_enable;
    logic [1:0] sat_speed   = 2'd3;
    logic [9:0] sat_zero10  = 10'd0;
    logic [9:0] sat_bird_x  = 10'd100;
    logic [9:0] sat_bird_y  = 10'd100;
    logic [5:0] sat_size    = 6'd0;
    logic       sat_low     = 1'b0;
    logic       sat_pixel, sat_collision, sat_pass;
    logic [7:0] sat_score;
    logic [1:0] sat_state;

    always #5 clk = ~clk;

    pipe_field_renderer #(.NUM_PIPES(4), .SPEED_DIVIDER(4), .SCORE_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
        .speed_sel(speed_sel), .hCount(hcount), .vCount(vcount),
        .bird_x(bird_x), .bird_y(bird_y), .bird_size(bird_size),
        .pipe_pixel(pipe_pixel), .collision(collision), .score(score),
        .pass_pulse(pass_pulse), .fsm_state(fsm_state)
    );

    pipe_field_renderer #(.NUM_PIPES(4), .SPEED_DIVIDER(1), .SCORE_W(8)) dut_sat (
        .clk(clk), .reset_n(sat_reset_n), .enable(sat_enable), .restart(sat_low),
        .speed_sel(sat_speed), .hCount(sat_zero10), .vCount(sat_zero10),
        .bird_x(sat_bird_x), .bird_y(sat_bird_y), .bird_size(sat_size),
        .pipe_pixel(sat_pixel), .collision(sat_collision), .score(sat_score),
        .pass_pulse(sat_pass), .fsm_state(sat_state)
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       pix;
    } pix_vec_t;

    pix_vec_t    pix_tab [10];
    int          scroll_exp [9];
    logic [10:0] exp_q [$];
    logic [10:0] prev_x0;
    logic [10:0] exp_x;
    logic [9:0]  l879, l880;
    logic        mon_on = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          main_pulses = 0;
    int          sat_pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] lfsr_after(input int n);
        logic [9:0] l;
        l = 10'h3FF;
        for (int k = 0; k < n; k++) l = {l[8:0], l[9] ^ l[6]};
        return l;
    endfunction

    // One clock; the scoreboard pops an expected pipe0 x whenever it moves.
    task automatic tick();
        @(negedge clk);
        if (mon_on && dut.pipe_x[0] != prev_x0) begin
            if (exp_q.size() == 0) begin
                check("x0_unexpected_move", int'(dut.pipe_x[0]), int'(prev_x0));
            end else begin
                exp_x = exp_q.pop_front();
                check("x0_step", int'(dut.pipe_x[0]), int'(exp_x));
            end
        end
        prev_x0 = dut.pipe_x[0];
        if (pass_pulse) main_pulses++;
        if (sat_pass) sat_pulses++;
    endtask

    initial begin
        pix_tab[0] = '{10'd880, 10'd10,  1'b1};
        pix_tab[1] = '{10'd919, 10'd10,  1'b1};
        pix_tab[2] = '{10'd920, 10'd10,  1'b0};
        pix_tab[3] = '{10'd879, 10'd10,  1'b0};
        pix_tab[4] = '{10'd880, 10'd60,  1'b0};
        pix_tab[5] = '{10'd900, 10'd169, 1'b0};
        pix_tab[6] = '{10'd880, 10'd170, 1'b1};
        pix_tab[7] = '{10'd900, 10'd59,  1'b1};
        pix_tab[8] = '{10'd900, 10'd300, 1'b1};
        pix_tab[9] = '{10'd0,   10'd0,   1'b0};
        scroll_exp = '{880, 880, 880, 880, 879, 879, 879, 879, 878};
        l879 = lfsr_after(879);
        l880 = lfsr_after(880);

        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; speed_sel = 2'd0;
        hcount = '0; vcount = '0;
        bird_x = 10'd100; bird_y = 10'd100; bird_size = 6'd10;
        sat_reset_n = 1'b0; sat_enable = 1'b0;
        prev_x0 = '0;
        repeat (3) tick();

        check("rst_state", int'(fsm_state), 0);
        check("rst_score", int'(score), 0);
        check("rst_pass_pulse", int'(pass_pulse), 0);
        check("rst_collision", int'(collision), 0);
        check("rst_x0", int'(dut.pipe_x[0]), 880);
        check("rst_x3", int'(dut.pipe_x[3]), 1540);
        check("rst_gap_top2", int'(dut.gap_top[2]), 180);
        check("rst_lfsr", int'(dut.lfsr), 10'h3FF);

        for (int k = 0; k < 10; k++) begin
            hcount = pix_tab[k].h;
            vcount = pix_tab[k].v;
            #1;
            check($sformatf("pixel_%0d", k), int'(pipe_pixel), int'(pix_tab[k].pix));
        end

        // Scroll at speed 1 until pipe0 recycles.
        for (int x = 879; x >= 1; x--) exp_q.push_back(11'(x));
        exp_q.push_back(11'd881);
        mon_on  = 1'b1;
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("scroll_x_%0d", k), int'(dut.pipe_x[0]), scroll_exp[k]);
        end

        for (int k = 0; k < 4000 && dut.pipe_x[0] != 11'd60; k++) tick();
        check("reach_x60", int'(dut.pipe_x[0]), 60);
        check("pre_pass_score", int'(score), 0);
        check("pre_pass_pulse", int'(pass_pulse), 0);
        for (int k = 0; k < 8 && dut.pipe_x[0] != 11'd59; k++) tick();
        check("pass_pulse_high", int'(pass_pulse), 1);
        check("pass_score", int'(score), 1);
        tick();
        check("pass_pulse_low", int'(pass_pulse), 0);

        for (int k = 0; k < 400 && dut.pipe_x[0] != 11'd1; k++) tick();
        check("reach_x1", int'(dut.pipe_x[0]), 1);
        for (int k = 0; k < 8 && dut.pipe_x[0] == 11'd1; k++) tick();
        check("recycle_x0", int'(dut.pipe_x[0]), 881);
        check("recycle_x1", int'(dut.pipe_x[1]), 220);
        check("recycle_x3", int'(dut.pipe_x[3]), 660);
        check("recycle_gap_top", int'(dut.gap_top[0]), 60 + int'(l879) % 261);
        check("recycle_gap_size", int'(dut.gap_size[0]), 110 + int'(l879[9:3]) % 41);
        check("recycle_lfsr", int'(dut.lfsr), int'(l880));
        check("recycle_score", int'(score), 1);
        check("pulse_count", main_pulses, 1);
        check("queue_drained_a", exp_q.size(), 0);

        // enable low holds position while staying in SCROLL.
        enable = 1'b0;
        repeat (12) tick();
        check("hold_x0", int'(dut.pipe_x[0]), 881);
        check("hold_x1", int'(dut.pipe_x[1]), 220);
        check("hold_state", int'(fsm_state), 1);

        mon_on  = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_state", int'(fsm_state), 0);
        check("restart_x0", int'(dut.pipe_x[0]), 880);
        check("restart_score", int'(score), 0);
        check("restart_gap_top1", int'(dut.gap_top[1]), 120);
        check("restart_lfsr", int'(dut.lfsr), 10'h3FF);

        // Speed 4, then reset mid-step overriding enable and restart.
        exp_q.push_back(11'd876);
        exp_q.push_back(11'd872);
        speed_sel = 2'd3;
        enable    = 1'b1;
        mon_on    = 1'b1;
        repeat (10) tick();
        check("speed4_x0", int'(dut.pipe_x[0]), 872);
        check("queue_drained_c", exp_q.size(), 0);
        mon_on  = 1'b0;
        reset_n = 1'b0;
        restart = 1'b1;
        tick();
        check("midrst_state", int'(fsm_state), 0);
        check("midrst_x0", int'(dut.pipe_x[0]), 880);
        check("midrst_x2", int'(dut.pipe_x[2]), 1320);
        check("midrst_cnt", int'(dut.step_cnt), 0);
        check("midrst_score", int'(score), 0);
        reset_n = 1'b1; restart = 1'b0; enable = 1'b0; speed_sel = 2'd0;
        tick();

        // Bird box sitting on pipe0's top solid section.
        bird_x = 10'd880; bird_y = 10'd0; bird_size = 6'd20;
        enable = 1'b1;
        tick();
        check("coll_enter_scroll", int'(fsm_state), 1);
        check("coll_low_first", int'(collision), 0);
`ifdef PIPE_COLLISION_EN
        tick();
        check("coll_high", int'(collision), 1);
        check("coll_state_halt", int'(fsm_state), 2);
        repeat (8) tick();
        check("coll_frozen_x0", int'(dut.pipe_x[0]), 880);
        check("coll_still_high", int'(collision), 1);
`else
        repeat (8) tick();
        check("nocoll_x0", int'(dut.pipe_x[0]), 878);
        check("nocoll_low", int'(collision), 0);
        check("nocoll_state", int'(fsm_state), 1);
`endif
        restart = 1'b1;
        tick();
        restart = 1'b0;
        enable  = 1'b0;
        check("coll_restart_state", int'(fsm_state), 0);
        check("coll_restart_x0", int'(dut.pipe_x[0]), 880);
        check("coll_restart_score", int'(score), 0);
        check("coll_restart_low", int'(collision), 0);

        // Saturation: a fast second instance runs well past 255 passes.
        sat_reset_n = 1'b1;
        sat_enable  = 1'b1;
        sat_pulses  = 0;
        repeat (6000) tick();
        check("sat_progress", int'(sat_pulses > 50), 1);
        check("sat_score_tracks", int'(sat_score), sat_pulses);
        repeat (14000) tick();
        check("sat_pulses_beyond", int'(sat_pulses > 255), 1);
        check("sat_score_255", int'(sat_score), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
